// File: rtl/ram1p_arbiter.sv
// ram1p_arbiter: round-robin sharing of one single-port byte-enable SRAM between two requesters,
// with an optional zero-fill of the whole array after reset.
module ram1p_arbiter #(
    parameter int DEPTH      = 64,
    parameter int WIDTH      = 44,
    parameter bit INIT_CLEAR = 1'b1,
    localparam int AW = $clog2(DEPTH),
    localparam int BW = (WIDTH - 1) / 8 + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             Req0Valid,
    output logic             Req0Ready,
    input  logic             Req0Write,
    input  logic [AW-1:0]    Req0Addr,
    input  logic [WIDTH-1:0] Req0Din,
    input  logic [BW-1:0]    Req0BWE,
    output logic             Rsp0Valid,
    output logic [WIDTH-1:0] Rsp0Data,
    input  logic             Req1Valid,
    output logic             Req1Ready,
    input  logic             Req1Write,
    input  logic [AW-1:0]    Req1Addr,
    input  logic [WIDTH-1:0] Req1Din,
    input  logic [BW-1:0]    Req1BWE,
    output logic             Rsp1Valid,
    output logic [WIDTH-1:0] Rsp1Data,
    output logic             RamCE,
    output logic             RamWE,
    output logic [AW-1:0]    RamAddr,
    output logic [WIDTH-1:0] RamDin,
    output logic [BW-1:0]    RamBWE,
    input  logic [WIDTH-1:0] RamDout,
    output logic             InitDone
);
    typedef enum logic {ST_INIT, ST_SERVE} state_t;

    state_t          r_state;
    logic [AW-1:0]   r_init_cnt;
    logic            r_last_grant;
    logic            r_rsp0;
    logic            r_rsp1;
    logic            r_init_done;
    logic            w_init;
    logic            w_serve;
    logic            w_g0;
    logic            w_g1;

    // RAM-facing signals are gated by resetn so nothing reaches the array while reset is held
    assign w_init  = resetn && r_state == ST_INIT;
    assign w_serve = resetn && r_state == ST_SERVE;
    assign w_g0    = w_serve && Req0Valid && (!Req1Valid || r_last_grant);
    assign w_g1    = w_serve && Req1Valid && (!Req0Valid || !r_last_grant);

    assign Req0Ready = w_g0;
    assign Req1Ready = w_g1;
    assign RamCE     = w_init || w_g0 || w_g1;
    assign RamWE     = w_init || (w_g0 && Req0Write) || (w_g1 && Req1Write);
    assign RamAddr   = w_init ? r_init_cnt : w_g1 ? Req1Addr : Req0Addr;
    assign RamDin    = w_init ? '0 : w_g1 ? Req1Din : Req0Din;
    assign RamBWE    = w_init ? '1 : w_g1 ? Req1BWE : Req0BWE;
    assign Rsp0Valid = r_rsp0;
    assign Rsp1Valid = r_rsp1;
    assign Rsp0Data  = RamDout;
    assign Rsp1Data  = RamDout;
    assign InitDone  = r_init_done;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= INIT_CLEAR ? ST_INIT : ST_SERVE;
            r_init_cnt   <= '0;
            r_last_grant <= 1'b1;
            r_rsp0       <= 1'b0;
            r_rsp1       <= 1'b0;
            r_init_done  <= !INIT_CLEAR;
        end else begin
            r_rsp0 <= w_g0 && !Req0Write;
            r_rsp1 <= w_g1 && !Req1Write;
            if (w_g0 || w_g1)
                r_last_grant <= w_g1;
            if (r_state == ST_INIT) begin
                r_init_cnt <= r_init_cnt + 1'b1;
                if (r_init_cnt == AW'(DEPTH - 1)) begin
                    r_state     <= ST_SERVE;
                    r_init_done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ram1p_arbiter.sv
// tb_ram1p_arbiter: randomized and directed traffic on both ports against a behavioural
// memory/arbitration model, plus literal checks of the clear length, tie order and data paths.
module tb_ram1p_arbiter;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        Req0Valid = 1'b0, Req0Write = 1'b0, Req1Valid = 1'b0, Req1Write = 1'b0;
    logic [5:0]  Req0Addr = '0, Req1Addr = '0, Req0BWE = '0, Req1BWE = '0;
    logic [43:0] Req0Din = '0, Req1Din = '0;
    logic        Req0Ready, Req1Ready, Rsp0Valid, Rsp1Valid;
    logic [43:0] Rsp0Data, Rsp1Data;
    logic        RamCE, RamWE, InitDone;
    logic [5:0]  RamAddr, RamBWE;
    logic [43:0] RamDin;
    logic [43:0] ram_dout;
    logic [43:0] ram [64];

    int tests = 0;
    int fails = 0;

    ram1p_arbiter #(.DEPTH(64), .WIDTH(44), .INIT_CLEAR(1'b1)) dut (
        .clk(clk), .resetn(resetn),
        .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0Write(Req0Write), .Req0Addr(Req0Addr),
        .Req0Din(Req0Din), .Req0BWE(Req0BWE), .Rsp0Valid(Rsp0Valid), .Rsp0Data(Rsp0Data),
        .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1Write(Req1Write), .Req1Addr(Req1Addr),
        .Req1Din(Req1Din), .Req1BWE(Req1BWE), .Rsp1Valid(Rsp1Valid), .Rsp1Data(Rsp1Data),
        .RamCE(RamCE), .RamWE(RamWE), .RamAddr(RamAddr), .RamDin(RamDin), .RamBWE(RamBWE),
        .RamDout(ram_dout), .InitDone(InitDone)
    );

    always #5 clk = ~clk;

    function automatic logic [43:0] bmask(input logic [5:0] be);
        for (int i = 0; i < 44; i++) bmask[i] = be[i/8];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // The physical array, seeded with garbage so the clear is observable
    initial for (int i = 0; i < 64; i++) ram[i] = 44'({$urandom(), $urandom()});
    always @(posedge clk)
        if (RamCE) begin
            if (RamWE) ram[RamAddr] <= (ram[RamAddr] & ~bmask(RamBWE)) | (RamDin & bmask(RamBWE));
            else ram_dout <= ram[RamAddr];
        end

    // Behavioural model: checks this cycle's outputs, then advances to the coming edge
    logic [43:0] m_mem [64];
    logic        m_known = 1'b0, m_rsp0 = 1'b0, m_rsp1 = 1'b0;
    logic [43:0] m_rsp0_d, m_rsp1_d;
    int          m_cnt = 0, m_last = 1;

    always @(negedge clk) begin
        int g;
        logic w;
        logic [5:0] a, be;
        logic [43:0] d;
        if (m_known) begin
            chk("rsp0_valid", 64'(Rsp0Valid), 64'(m_rsp0));
            chk("rsp1_valid", 64'(Rsp1Valid), 64'(m_rsp1));
            if (m_rsp0) chk("rsp0_data", 64'(Rsp0Data), 64'(m_rsp0_d));
            if (m_rsp1) chk("rsp1_data", 64'(Rsp1Data), 64'(m_rsp1_d));
            chk("init_done", 64'(InitDone), 64'(m_cnt >= 64));
        end
        if (!resetn) begin
            chk("rst_ram_ce", 64'(RamCE), 64'(0));
            chk("rst_ready", 64'({Req1Ready, Req0Ready}), 64'(0));
            m_known = 1'b1; m_cnt = 0; m_last = 1; m_rsp0 = 1'b0; m_rsp1 = 1'b0;
        end else if (m_known) begin
            m_rsp0 = 1'b0; m_rsp1 = 1'b0;
            if (m_cnt < 64) begin
                chk("init_ram", 64'({RamCE, RamWE, RamAddr, RamDin, RamBWE}), 64'({2'b11, 6'(m_cnt), 44'h0, 6'h3F}));
                chk("init_ready", 64'({Req1Ready, Req0Ready}), 64'(0));
                m_mem[m_cnt] = '0;
                m_cnt++;
            end else begin
                g = (Req0Valid && Req1Valid) ? 1 - m_last : Req0Valid ? 0 : Req1Valid ? 1 : -1;
                chk("ready", 64'({Req1Ready, Req0Ready}), g == 0 ? 64'd1 : g == 1 ? 64'd2 : 64'd0);
                chk("ram_ce", 64'(RamCE), 64'(g >= 0));
                if (g >= 0) begin
                    w  = g ? Req1Write : Req0Write;
                    a  = g ? Req1Addr : Req0Addr;
                    d  = g ? Req1Din : Req0Din;
                    be = g ? Req1BWE : Req0BWE;
                    chk("ram_we", 64'(RamWE), 64'(w));
                    chk("ram_addr", 64'(RamAddr), 64'(a));
                    if (w) begin
                        chk("ram_din", 64'(RamDin), 64'(d));
                        chk("ram_bwe", 64'(RamBWE), 64'(be));
                        m_mem[a] = (m_mem[a] & ~bmask(be)) | (d & bmask(be));
                    end else if (g == 0) begin
                        m_rsp0 = 1'b1; m_rsp0_d = m_mem[a];
                    end else begin
                        m_rsp1 = 1'b1; m_rsp1_d = m_mem[a];
                    end
                    m_last = g;
                end
            end
        end
    end

    task automatic req(input int p, input logic w, input logic [5:0] a, input logic [43:0] d, input logic [5:0] be);
        int n = 0;
        @(posedge clk); #1;
        if (p == 0) begin Req0Valid = 1; Req0Write = w; Req0Addr = a; Req0Din = d; Req0BWE = be; end
        else begin Req1Valid = 1; Req1Write = w; Req1Addr = a; Req1Din = d; Req1BWE = be; end
        @(negedge clk);
        while (!(p == 0 ? Req0Ready : Req1Ready) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("req_timeout", 64'(n), 64'(0));
        @(posedge clk); #1;
        Req0Valid = 0; Req1Valid = 0;
    endtask

    task automatic count_init(input string name);
        int cyc = 0, we = 0;
        while (cyc < 200) begin
            @(negedge clk);
            if (InitDone) break;
            if (RamCE && RamWE) we++;
            cyc++;
        end
        chk({name, "_len"}, 64'(cyc), 64'd64);
        chk({name, "_writes"}, 64'(we), 64'd64);
    endtask

    initial begin
        logic [7:0] seq;
        logic a0, a1;
        repeat (3) @(posedge clk);
        #1 resetn = 1;
        count_init("init");
        // Tie sequence straight after reset: LastGrant=1 so port 0 wins first
        @(posedge clk); #1;
        Req0Valid = 1; Req0Write = 0; Req0Addr = 1;
        Req1Valid = 1; Req1Write = 0; Req1Addr = 2;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seq[i] = Req1Ready;
            chk("tie_one_grant", 64'(Req0Ready ^ Req1Ready), 64'd1);
            @(posedge clk); #1;
        end
        Req0Valid = 0; Req1Valid = 0;
        chk("tie_seq", 64'(seq), 64'(8'b10101010));
        req(0, 1, 5, 44'h123456789AB, 6'h3F);
        req(0, 0, 5, 44'h0, 6'h0);
        @(negedge clk);
        chk("rd5_valid", 64'({Rsp1Valid, Rsp0Valid}), 64'd1);
        chk("rd5_data", 64'(Rsp0Data), 64'h123456789AB);
        req(1, 1, 9, 44'hFFFFFFFFFFF, 6'h3F);
        req(0, 1, 9, 44'h0, 6'b000001);
        req(1, 0, 9, 44'h0, 6'h0);
        @(negedge clk);
        chk("bwe_data", 64'(Rsp1Data), 64'hFFFFFFFFF00);
        req(0, 1, 3, 44'h333, 6'h3F);
        req(1, 1, 4, 44'h444, 6'h3F);
        @(posedge clk); #1;
        Req1Valid = 1; Req1Write = 0; Req1Addr = 3;
        repeat (3) @(posedge clk);
        #1 Req1Valid = 0;
        Req0Valid = 1; Req0Write = 0; Req0Addr = 4;
        @(negedge clk);
        chk("p1_rsp_data", 64'({Rsp1Valid, Rsp1Data}), 64'({1'b1, 44'h333}));
        @(posedge clk); #1 Req0Valid = 0;
        @(negedge clk);
        chk("p0_rsp_data", 64'({Rsp1Valid, Rsp0Valid, Rsp0Data}), 64'({2'b01, 44'h444}));
        // Random traffic on both ports, holding each request until accepted
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            a0 = Req0Ready; a1 = Req1Ready;
            @(posedge clk); #1;
            if (!Req0Valid || a0) begin
                Req0Valid = $urandom_range(0, 3) != 0; Req0Write = 1'($urandom_range(0, 1));
                Req0Addr = 6'($urandom_range(0, 15)); Req0Din = 44'({$urandom(), $urandom()});
                Req0BWE = 6'($urandom());
            end
            if (!Req1Valid || a1) begin
                Req1Valid = $urandom_range(0, 3) != 0; Req1Write = 1'($urandom_range(0, 1));
                Req1Addr = 6'($urandom_range(0, 15)); Req1Din = 44'({$urandom(), $urandom()});
                Req1BWE = 6'($urandom());
            end
        end
        Req0Valid = 0; Req1Valid = 0;
        // Reset during the clear at InitCnt=20, then a full clear again
        @(posedge clk); #1 resetn = 0;
        @(posedge clk); #1 resetn = 1;
        repeat (20) @(posedge clk);
        #1 resetn = 0;
        @(posedge clk); #1 resetn = 1;
        count_init("reinit");
        // Reset with a read response in flight
        @(posedge clk); #1;
        Req0Valid = 1; Req0Write = 0; Req0Addr = 5;
        @(negedge clk);
        chk("inflight_grant", 64'(Req0Ready), 64'd1);
        @(posedge clk); #1;
        Req0Valid = 0; resetn = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("inflight_dropped", 64'({Rsp1Valid, Rsp0Valid}), 64'd0);
        @(posedge clk); #1 resetn = 1;
        count_init("final");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
